// File: rtl/boa_peri_gpio_irq.sv
// Parametrised Boa32 GPIO: atomic set/clr/tgl outputs, synchronised inputs, edge-detect pending bits, level irq.
// Optional per-pin glitch filter (register 0x28) when BOA_GPIO_FILTER_EN is defined.
module boa_peri_gpio_irq #(
    parameter logic [31:0] addr        = 32'h8000_0000,
    parameter int unsigned width       = 32,
    parameter int unsigned sync_stages = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_bus_re,
    input  logic [3:0]       i_bus_we,
    input  logic [31:0]      i_bus_addr,
    input  logic [31:0]      i_bus_wdata,
    output logic [31:0]      o_bus_rdata,
    output logic             o_bus_ready,
    output logic [width-1:0] o_pin_out,
    output logic [width-1:0] o_pin_oe,
    input  logic [width-1:0] i_pin_in,
    output logic             o_irq
);

    localparam logic [3:0] A_OUT  = 4'h0;
    localparam logic [3:0] A_OE   = 4'h1;
    localparam logic [3:0] A_IN   = 4'h2;
    localparam logic [3:0] A_SET  = 4'h3;
    localparam logic [3:0] A_CLR  = 4'h4;
    localparam logic [3:0] A_TGL  = 4'h5;
    localparam logic [3:0] A_RISE = 4'h6;
    localparam logic [3:0] A_FALL = 4'h7;
    localparam logic [3:0] A_PEND = 4'h8;
    localparam logic [3:0] A_MASK = 4'h9;
`ifdef BOA_GPIO_FILTER_EN
    localparam logic [3:0] A_FILT = 4'hA;
`endif

    logic [width-1:0] r_out, r_oe, r_rise, r_fall, r_pend, r_mask, r_in_d;
    logic [width-1:0] r_sync [sync_stages];
    logic [31:0]      r_rdata;
    logic             r_ready, r_irq;

    logic             w_req, w_wr, w_aligned, w_unused;
    logic [3:0]       w_idx;
    logic [31:0]      w_bmask, w_rdata;
    logic [width-1:0] w_m, w_wm, w_sync, w_in, w_edge, w_clr;

    assign w_aligned = (i_bus_addr[1:0] == 2'b00);
    assign w_idx     = i_bus_addr[5:2];
    assign w_req     = (i_bus_addr[31:6] == addr[31:6]) && (i_bus_re || (|i_bus_we));
    assign w_wr      = w_req && (|i_bus_we) && w_aligned;
    assign w_bmask   = {{8{i_bus_we[3]}}, {8{i_bus_we[2]}}, {8{i_bus_we[1]}}, {8{i_bus_we[0]}}};
    assign w_m       = w_bmask[width-1:0];
    assign w_wm      = i_bus_wdata[width-1:0] & w_m;
    assign w_unused  = &{1'b0, i_bus_wdata};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < sync_stages; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= i_pin_in;
            for (int unsigned i = 1; i < sync_stages; i++) r_sync[i] <= r_sync[i-1];
        end
    end
    assign w_sync = r_sync[sync_stages-1];

`ifdef BOA_GPIO_FILTER_EN
    logic [3:0]       r_filt_cfg;
    logic [width-1:0] r_filt;
    logic [3:0]       r_cnt [width];
    logic [width-1:0] w_commit;

    // Commit is combinational on the qualifying cycle so FILT=0 adds no latency.
    always_comb begin
        w_commit = '0;
        for (int unsigned i = 0; i < width; i++)
            w_commit[i] = (w_sync[i] != r_filt[i]) && (r_cnt[i] >= r_filt_cfg);
    end
    assign w_in = r_filt ^ w_commit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_filt     <= '0;
            r_filt_cfg <= '0;
            for (int unsigned i = 0; i < width; i++) r_cnt[i] <= '0;
        end else begin
            r_filt <= w_in;
            for (int unsigned i = 0; i < width; i++)
                r_cnt[i] <= ((w_sync[i] == r_filt[i]) || w_commit[i]) ? 4'd0 : r_cnt[i] + 4'd1;
            if (w_wr && (w_idx == A_FILT) && i_bus_we[0])
                r_filt_cfg <= i_bus_wdata[3:0];
        end
    end
`else
    assign w_in = w_sync;
`endif

    assign w_edge = (w_in & ~r_in_d & r_rise) | (~w_in & r_in_d & r_fall);
    assign w_clr  = (w_wr && (w_idx == A_PEND)) ? w_wm : '0;

    always_comb begin
        w_rdata = '0;
        if (w_aligned) begin
            case (w_idx)
                A_OUT:  w_rdata = 32'(r_out);
                A_OE:   w_rdata = 32'(r_oe);
                A_IN:   w_rdata = 32'(w_in);
                A_RISE: w_rdata = 32'(r_rise);
                A_FALL: w_rdata = 32'(r_fall);
                A_PEND: w_rdata = 32'(r_pend);
                A_MASK: w_rdata = 32'(r_mask);
`ifdef BOA_GPIO_FILTER_EN
                A_FILT: w_rdata = {28'd0, r_filt_cfg};
`endif
                default: w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out   <= '0;
            r_oe    <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_mask  <= '0;
            r_pend  <= '0;
            r_in_d  <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_ready <= w_req;
            r_rdata <= (w_req && i_bus_re) ? w_rdata : '0;
            r_in_d  <= w_in;
            // New edges are ORed in after the W1C so a same-cycle set wins.
            r_pend  <= (r_pend & ~w_clr) | w_edge;
            r_irq   <= |(r_pend & r_mask);
            if (w_wr) begin
                case (w_idx)
                    A_OUT:  r_out  <= (r_out  & ~w_m) | w_wm;
                    A_SET:  r_out  <= r_out | w_wm;
                    A_CLR:  r_out  <= r_out & ~w_wm;
                    A_TGL:  r_out  <= r_out ^ w_wm;
                    A_OE:   r_oe   <= (r_oe   & ~w_m) | w_wm;
                    A_RISE: r_rise <= (r_rise & ~w_m) | w_wm;
                    A_FALL: r_fall <= (r_fall & ~w_m) | w_wm;
                    A_MASK: r_mask <= (r_mask & ~w_m) | w_wm;
                    default: ;
                endcase
            end
        end
    end

    assign o_bus_rdata = r_rdata;
    assign o_bus_ready = r_ready;
    assign o_pin_out   = r_out;
    assign o_pin_oe    = r_oe;
    assign o_irq       = r_irq;

endmodule

// File: tb/tb_boa_peri_gpio_irq.sv
// Directed bench for boa_peri_gpio_irq: a 32-pin instance and an 8-pin instance at a second base address.
module tb_boa_peri_gpio_irq;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] BASE8 = 32'h8000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        re = 1'b0;
    logic [3:0]  we = 4'h0;
    logic [31:0] baddr = 32'h0, wdata = 32'h0;
    logic [31:0] rdata32, rdata8, pin_out32, oe32;
    logic [31:0] pin_in32 = 32'h0;
    logic        ready32, ready8, irq32, irq8;
    logic [7:0]  pin_out8, oe8;
    logic [7:0]  pin_in8 = 8'h0;
    logic [31:0] v;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    boa_peri_gpio_irq #(.addr(BASE), .width(32), .sync_stages(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_bus_re(re), .i_bus_we(we), .i_bus_addr(baddr),
        .i_bus_wdata(wdata), .o_bus_rdata(rdata32), .o_bus_ready(ready32),
        .o_pin_out(pin_out32), .o_pin_oe(oe32), .i_pin_in(pin_in32), .o_irq(irq32));

    boa_peri_gpio_irq #(.addr(BASE8), .width(8), .sync_stages(2)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_bus_re(re), .i_bus_we(we), .i_bus_addr(baddr),
        .i_bus_wdata(wdata), .o_bus_rdata(rdata8), .o_bus_ready(ready8),
        .o_pin_out(pin_out8), .o_pin_oe(oe8), .i_pin_in(pin_in8), .o_irq(irq8));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One bus request cycle; returns rdata from the addressed instance.
    task automatic acc(input string tag, input logic [31:0] a, input logic r,
                       input logic [3:0] w, input logic [31:0] d, output logic [31:0] rd);
        @(negedge clk);
        baddr = a; re = r; we = w; wdata = d;
        @(posedge clk);
        #1;
        if (a[8]) begin
            chk({tag, "/ready8"}, 32'(ready8), 32'd1);
            chk({tag, "/idle32"}, 32'(ready32), 32'd0);
            rd = rdata8;
        end else begin
            chk({tag, "/ready32"}, 32'(ready32), 32'd1);
            rd = rdata32;
        end
        baddr = '0; re = 1'b0; we = '0; wdata = '0;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        logic [31:0] dummy;
        acc(tag, a, 1'b0, w, d, dummy);
    endtask

    task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] got;
        acc(tag, a, 1'b1, 4'h0, 32'h0, got);
        chk(tag, got, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pin_out", pin_out32, 32'h0);
        chk("rst_oe", oe32, 32'h0);
        chk("rst_irq", 32'(irq32), 32'h0);
        chk("rst_ready", 32'(ready32), 32'h0);
        chk("rst_rdata", rdata32, 32'h0);
        chk("rst_pin_out8", 32'(pin_out8), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        wr("out_f0", BASE + 32'h00, 4'hF, 32'h0000_00F0);
        chk("pin_out_f0", pin_out32, 32'h0000_00F0);
        @(posedge clk); #1;
        chk("ready_pulse_end", 32'(ready32), 32'h0);
        wr("set_0f", BASE + 32'h0C, 4'hF, 32'h0000_000F);
        chk("pin_out_ff", pin_out32, 32'h0000_00FF);
        wr("clr_3c", BASE + 32'h10, 4'hF, 32'h0000_003C);
        chk("pin_out_c3", pin_out32, 32'h0000_00C3);
        wr("tgl_ff", BASE + 32'h14, 4'hF, 32'h0000_00FF);
        chk("pin_out_3c", pin_out32, 32'h0000_003C);
        rdchk("rd_out", BASE + 32'h00, 32'h0000_003C);
        rdchk("rd_set_wo", BASE + 32'h0C, 32'h0);

        wr("out_zero", BASE + 32'h00, 4'hF, 32'h0);
        wr("oe_byte1", BASE + 32'h04, 4'b0010, 32'hAABB_CCDD);
        chk("pin_oe_byte1", oe32, 32'h0000_CC00);
        rdchk("rd_oe", BASE + 32'h04, 32'h0000_CC00);

        wr("rise_en", BASE + 32'h18, 4'hF, 32'h1);
        wr("irq_mask", BASE + 32'h24, 4'hF, 32'h1);
        @(negedge clk);
        pin_in32[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("irq_not_yet", 32'(irq32), 32'h0);
        @(posedge clk); #1;
        chk("irq_at_4", 32'(irq32), 32'h1);
        rdchk("pend_set", BASE + 32'h20, 32'h1);

        wr("w1c", BASE + 32'h20, 4'hF, 32'h1);
        chk("irq_hold_w1c", 32'(irq32), 32'h1);
        @(posedge clk); #1;
        chk("irq_clr", 32'(irq32), 32'h0);
        rdchk("pend_clr", BASE + 32'h20, 32'h0);

        @(negedge clk);
        pin_in32[0] = 1'b0;
        repeat (5) @(posedge clk);
        rdchk("fall_no_pend", BASE + 32'h20, 32'h0);
        chk("fall_no_irq", 32'(irq32), 32'h0);

        @(negedge clk);
        pin_in32[0] = 1'b1;
        repeat (2) @(posedge clk);
        wr("w1c_conflict", BASE + 32'h20, 4'hF, 32'h1);
        @(posedge clk); #1;
        chk("irq_conflict", 32'(irq32), 32'h1);
        rdchk("pend_conflict", BASE + 32'h20, 32'h1);
        wr("mask_off", BASE + 32'h24, 4'hF, 32'h0);
        @(posedge clk); #1;
        chk("irq_masked", 32'(irq32), 32'h0);
        rdchk("pend_sticky", BASE + 32'h20, 32'h1);
        wr("w1c_all", BASE + 32'h20, 4'hF, 32'hFFFF_FFFF);
        rdchk("pend_cleared", BASE + 32'h20, 32'h0);

        rdchk("rd_unmapped30", BASE + 32'h30, 32'h0);
        rdchk("rd_unaligned", BASE + 32'h02, 32'h0);
        wr("wr_unaligned", BASE + 32'h02, 4'hF, 32'hFFFF_FFFF);
        rdchk("out_after_unal", BASE + 32'h00, 32'h0);

        acc("rw_same", BASE + 32'h00, 1'b1, 4'hF, 32'h0000_0055, v);
        chk("rw_prewrite", v, 32'h0);
        rdchk("rw_postwrite", BASE + 32'h00, 32'h0000_0055);
        chk("pin_out_55", pin_out32, 32'h0000_0055);

        chk("dut8_untouched", 32'(pin_out8), 32'h0);
        wr("w8_out", BASE8 + 32'h00, 4'hF, 32'hFFFF_FFFF);
        chk("pin_out8_ff", 32'(pin_out8), 32'h0000_00FF);
        rdchk("rd8_out", BASE8 + 32'h00, 32'h0000_00FF);
        rdchk("dut32_isolated", BASE + 32'h00, 32'h0000_0055);

        @(negedge clk);
        pin_in32 = 32'h0000_A501;
        repeat (3) @(posedge clk);
        rdchk("rd_in", BASE + 32'h08, 32'h0000_A501);

`ifdef BOA_GPIO_FILTER_EN
        wr("filt_cfg", BASE + 32'h28, 4'hF, 32'h3);
        rdchk("rd_filt", BASE + 32'h28, 32'h3);
        wr("rise_en2", BASE + 32'h18, 4'hF, 32'h2);
        wr("w1c_pre_filt", BASE + 32'h20, 4'hF, 32'hFFFF_FFFF);
        @(negedge clk);
        pin_in32[1] = 1'b1;
        repeat (3) @(negedge clk);
        pin_in32[1] = 1'b0;
        repeat (8) @(posedge clk);
        rdchk("filt_short_pend", BASE + 32'h20, 32'h0);
        rdchk("filt_short_in", BASE + 32'h08, 32'h0000_A501);
        @(negedge clk);
        pin_in32[1] = 1'b1;
        repeat (4) @(negedge clk);
        pin_in32[1] = 1'b0;
        repeat (8) @(posedge clk);
        rdchk("filt_long_pend", BASE + 32'h20, 32'h2);
        rdchk("filt_long_in", BASE + 32'h08, 32'h0000_A501);
`else
        wr("wr_filt_absent", BASE + 32'h28, 4'hF, 32'hF);
        rdchk("rd_filt_absent", BASE + 32'h28, 32'h0);
`endif

        @(negedge clk);
        baddr = BASE; re = 1'b1;
        @(posedge clk); #1;
        chk("midacc_ready", 32'(ready32), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midacc_rst_ready", 32'(ready32), 32'h0);
        chk("midacc_rst_rdata", rdata32, 32'h0);
        chk("midacc_rst_out", pin_out32, 32'h0);
        chk("midacc_rst_oe", oe32, 32'h0);
        chk("midacc_rst_out8", 32'(pin_out8), 32'h0);
        re = 1'b0; baddr = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/boa_peri_gpio_irq.md
Name: boa_peri_gpio_irq

Overview:
Parametrised GPIO peripheral on the Boa³² peripheral bus and the successor to the fixed 32-pin GPIO block.
- Pin count, synchroniser depth and base address are configurable.
- Atomic set/clear/toggle output registers.
- Per-pin rising/falling edge detection with sticky pending bits and a single level interrupt output to the platform interrupt controller.

Parameters:
addr, 32'h8000_0000, base address; the block decodes addr..addr+0x3F.
width, 32, number of pins, 1..32; unused upper register bits read 0 and ignore writes.
sync_stages, 2, input synchroniser depth, 2..4.

Ports:
clk  input  1  peripheral bus clock
rst  input  1  asynchronous active-low reset
bus  boa_mem_bus.MEM  -  peripheral bus; uses re, we[3:0], addr, wdata, rdata, ready
pin_out  output  width  output values
pin_oe  output  width  output enables
pin_in  input  width  raw asynchronous inputs
irq  output  1  level interrupt, high while any enabled pending bit is set

Behaviour:
- Reset (rst low, asynchronous): pin_out=0, pin_oe=0, rise_en=0, fall_en=0, pending=0, synchroniser flops=0, bus.rdata=0, bus.ready=0, irq=0.
- Register map, word offsets from addr:
  - 0x00 OUT: rw.
  - 0x04 OE: rw.
  - 0x08 IN: ro, synchronised value.
  - 0x0C OUT_SET: wo, OUT |= wdata.
  - 0x10 OUT_CLR: wo, OUT &= ~wdata.
  - 0x14 OUT_TGL: wo, OUT ^= wdata.
  - 0x18 RISE_EN: rw.
  - 0x1C FALL_EN: rw.
  - 0x20 PENDING: read; write-1-to-clear.
  - 0x24 IRQ_MASK: rw; irq = |(pending & mask).
  - Write-only registers read 0.
- Bus access:
  - Access occurs when re or any we bit is high and addr[31:6] matches addr[31:6].
  - we[n] gates byte n of rw registers and of the set/clr/tgl/W1C masks.
  - ready pulses high exactly one cycle after the request cycle.
  - rdata is registered and valid with ready; rdata is 0 on non-read cycles.
  - re and we together: the write is performed and rdata returns the pre-write value.
- Unmapped offsets (0x28..0x3C) or addr[1:0]≠0: reads return 0, writes ignored, ready still pulses.
- pin_out and pin_oe update the cycle after the write cycle, i.e. visible together with ready.
- Synchroniser: sync_stages flops per pin; IN reflects pin_in after sync_stages cycles.
- Edge detect: compares the last synchroniser stage with a one-cycle delayed copy.
  - Rising edge on pin i with rise_en[i]: pending[i] set on the next clk.
  - Falling edge on pin i with fall_en[i]: pending[i] set on the next clk.
  - Pin-change to pending is sync_stages+1 cycles.
- Pending bits are sticky regardless of IRQ_MASK; masking affects irq only.
- Set and W1C on the same bit in the same cycle: set wins, bit stays 1.
- irq is registered: it asserts the cycle after pending&mask becomes nonzero and deasserts the cycle after it becomes zero.
- Writing RISE_EN/FALL_EN does not generate edges and does not clear pending.
- Reset mid-access: ready is forced 0 and the transaction is dropped with no retry.

Optional Feature:
- Macro: BOA_GPIO_FILTER_EN.
- Defined:
  - Per-pin glitch filter between the synchroniser and IN/edge detect, with a 4-bit counter per pin.
  - The filtered value changes only after the synchronised input has held a new level for FILT+1 consecutive cycles.
  - FILT is register 0x28 (rw, bits[3:0], reset 0).
  - FILT=0 means filter transparent, adding 0 cycles.
  - Any level bounce restarts the counter.
- Undefined: no filter logic; offset 0x28 is unmapped and reads 0.

Test Plan:
- Reset → all outputs 0.
  - Write OUT=0x0000_00F0 with we=4'b1111 → pin_out=0xF0 one cycle later, ready one cycle after request.
  - Then OUT_SET 0x0F → 0xFF; OUT_CLR 0x3C → 0xC3; OUT_TGL 0xFF → 0x3C.
- Byte strobe: OUT=0, write OE 0xAABBCCDD with we=4'b0010 → OE reads 0x0000CC00.
- RISE_EN=0x1, IRQ_MASK=0x1; pin_in[0] 0→1 → pending=0x1 at 3 cycles, irq=1 at 4 cycles (sync_stages=2).
  - Write PENDING 0x1 → irq=0 one cycle later.
  - pin_in[0] 1→0 → no pending.
- Same-cycle conflict: rising edge reaches pending in the same cycle as a W1C write of 0x1 → pending stays 0x1, irq stays 1.
- width=8: write OUT 0xFFFF_FFFF → reads 0x0000_00FF.
  - Read offset 0x30 → 0 with ready.
  - Read addr+0x2 → 0, no state change.
- With BOA_GPIO_FILTER_EN and FILT=3: a 3-cycle pulse on pin_in[1] → IN[1] stays 0; a 4-cycle pulse → IN[1]=1, pending set if FALL_EN/RISE_EN=0x2.
